// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      HOLD = 2'b10
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle of the sequential ALU.
interface seq_alu_if #(
   parameter int WIDTH = 8
) ();

   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] InputA;
   logic [WIDTH-1:0] InputB;
   logic [2:0]       OP;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] Out;
   logic             Zero;
   logic             LT;
   logic             Carry;

   modport master (
      output InValid, InputA, InputB, OP, OutReady,
      input  InReady, OutValid, Out, Zero, LT, Carry
   );

   modport slave (
      input  InValid, InputA, InputB, OP, OutReady,
      output InReady, OutValid, Out, Zero, LT, Carry
   );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one bit of b per cycle, LSB first, into a 2*WIDTH accumulator.
module shift_add_mul #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [CW-1:0]      cnt_r;
   logic               busy_r;
   logic [2*WIDTH-1:0] addend_s;
   logic               last_s;

   // Partial product of the current bit; product already includes it so the
   // final value is available in the cycle done is high.
   always_comb begin
      addend_s = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
      last_s   = busy_r && (cnt_r == CW'(WIDTH - 1));
      product  = acc_r + addend_s;
      done     = last_s;
   end

   // Accumulator, shifting operands and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r    <= {(2*WIDTH){1'b0}};
         mcand_r  <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         cnt_r    <= {CW{1'b0}};
         busy_r   <= 1'b0;
      end else if (start) begin
         acc_r    <= {(2*WIDTH){1'b0}};
         mcand_r  <= {{WIDTH{1'b0}}, a};
         mplier_r <= b;
         cnt_r    <= {CW{1'b0}};
         busy_r   <= 1'b1;
      end else if (busy_r) begin
         acc_r    <= product;
         mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
         cnt_r    <= cnt_r + CW'(1);
         busy_r   <= !last_s;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU: single-cycle ops plus an iterative multiply,
// with result and flags held in output registers until the consumer takes them.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input logic      Clk,
   input logic      Reset_n,
   seq_alu_if.slave bus
);

   state_t             state_r;
   state_t             state_nxt_s;
   logic               in_fire_s;
   logic               is_mul_s;
   logic               mul_start_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] product_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     diff_s;
   logic [WIDTH-1:0]   res_s;
   logic               res_carry_s;
   logic               res_zero_s;
   logic               res_lt_s;
   logic               lt_s;
   logic               mul_zero_s;
   logic [WIDTH-1:0]   out_r;
   logic               out_valid_r;
   logic               zero_r;
   logic               lt_r;
   logic               carry_r;
   logic               lt_pend_r;

   // A finished result can be replaced in the same cycle it is consumed.
   assign bus.InReady = (state_r == IDLE) || ((state_r == HOLD) && bus.OutReady);
   assign in_fire_s   = bus.InValid && bus.InReady;
   assign is_mul_s    = (bus.OP == OP_MUL);
   assign mul_start_s = in_fire_s && is_mul_s;
   assign mul_zero_s  = (product_s[WIDTH-1:0] == {WIDTH{1'b0}});

   assign bus.OutValid = out_valid_r;
   assign bus.Out      = out_r;
   assign bus.Zero     = zero_r;
   assign bus.LT       = lt_r;
   assign bus.Carry    = carry_r;

   shift_add_mul #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_mul (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .start   (mul_start_s),
      .a       (bus.InputA),
      .b       (bus.InputB),
      .done    (mul_done_s),
      .product (product_s)
   );

   // Single-cycle operation mux and its flags.
   always_comb begin
      sum_s       = {1'b0, bus.InputA} + {1'b0, bus.InputB};
      diff_s      = {1'b0, bus.InputA} - {1'b0, bus.InputB};
      lt_s        = (bus.InputA < bus.InputB);
      res_s       = {WIDTH{1'b0}};
      res_carry_s = 1'b0;
      case (bus.OP)
         OP_ADD: begin
            res_s       = sum_s[WIDTH-1:0];
            res_carry_s = sum_s[WIDTH];
         end
         OP_SUB: begin
            res_s       = diff_s[WIDTH-1:0];
            res_carry_s = diff_s[WIDTH];
         end
         OP_AND:  res_s = bus.InputA & bus.InputB;
         OP_OR:   res_s = bus.InputA | bus.InputB;
         OP_XOR:  res_s = bus.InputA ^ bus.InputB;
         OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, lt_s};
         default: res_s = {WIDTH{1'b0}};
      endcase
      res_lt_s   = (bus.OP == OP_RSVD) ? 1'b0 : lt_s;
      res_zero_s = (res_s == {WIDTH{1'b0}});
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_fire_s) state_nxt_s = is_mul_s ? BUSY : HOLD;
            else           state_nxt_s = IDLE;
         end
         BUSY: begin
            if (mul_done_s) state_nxt_s = HOLD;
            else            state_nxt_s = BUSY;
         end
         HOLD: begin
            if (in_fire_s)         state_nxt_s = is_mul_s ? BUSY : HOLD;
            else if (bus.OutReady) state_nxt_s = IDLE;
            else                   state_nxt_s = HOLD;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_r <= IDLE;
      else          state_r <= state_nxt_s;
   end

   // Output registers; LT of a multiply is captured at accept time.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_r       <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         zero_r      <= 1'b0;
         lt_r        <= 1'b0;
         carry_r     <= 1'b0;
         lt_pend_r   <= 1'b0;
      end else begin
         out_valid_r <= (state_nxt_s == HOLD);
         if (in_fire_s && !is_mul_s) begin
            out_r   <= res_s;
            zero_r  <= res_zero_s;
            lt_r    <= res_lt_s;
            carry_r <= res_carry_s;
         end else if (mul_done_s) begin
            out_r   <= product_s[WIDTH-1:0];
            zero_r  <= mul_zero_s;
            lt_r    <= lt_pend_r;
            carry_r <= |product_s[2*WIDTH-1:WIDTH];
         end
         if (mul_start_s) lt_pend_r <= lt_s;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8 and WIDTH=16 against a transaction-level model.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst8_n;
   logic rst16_n;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(8))  bus8  ();
   seq_alu_if #(.WIDTH(16)) bus16 ();

   seq_alu #(.WIDTH(8))  dut8  (.Clk(clk), .Reset_n(rst8_n),  .bus(bus8));
   seq_alu #(.WIDTH(16)) dut16 (.Clk(clk), .Reset_n(rst16_n), .bus(bus16));

   typedef struct {
      logic [63:0] out;
      logic        zero;
      logic        lt;
      logic        carry;
      int          acc;
      int          due;
   } item_t;

   typedef struct {
      logic [63:0] out;
      logic        zero;
      logic        lt;
      logic        carry;
      int          acc;
      int          xfer;
   } rec_t;

   typedef struct {
      logic        inv;
      logic        inr;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        ov;
      logic        ordy;
      logic [63:0] out;
      logic        zero;
      logic        lt;
      logic        carry;
   } pins_t;

   item_t q  [2][$];
   rec_t  lg [2][$];
   int    n_acc [2] = '{0, 0};
   int    cycle    = 0;
   int    n_checks = 0;
   int    n_fail   = 0;

   // Result of one operation straight from the opcode definitions.
   function automatic item_t model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int w);
      item_t       it;
      logic [63:0] mask;
      logic [63:0] full;
      mask     = (64'd1 << w) - 64'd1;
      it.lt    = (a < b);
      it.carry = 1'b0;
      it.acc   = 0;
      it.due   = 0;
      case (op)
         OP_ADD: begin full = a + b; it.out = full & mask; it.carry = (full > mask); end
         OP_SUB: begin it.out = (a - b) & mask; it.carry = (a < b); end
         OP_AND: it.out = a & b;
         OP_OR:  it.out = a | b;
         OP_XOR: it.out = a ^ b;
         OP_SLT: it.out = (a < b) ? 64'd1 : 64'd0;
         OP_MUL: begin full = a * b; it.out = full & mask; it.carry = ((full >> w) != 64'd0); end
         default: begin it.out = 64'd0; it.lt = 1'b0; end
      endcase
      it.zero = (it.out == 64'd0);
      return it;
   endfunction

   function automatic int width_of(input int d);
      return (d == 0) ? 8 : 16;
   endfunction

   function automatic logic rst_of(input int d);
      return (d == 0) ? rst8_n : rst16_n;
   endfunction

   function automatic pins_t pins(input int d);
      pins_t p;
      if (d == 0) begin
         p.inv = bus8.InValid; p.inr = bus8.InReady; p.op = bus8.OP;
         p.a = {56'd0, bus8.InputA}; p.b = {56'd0, bus8.InputB};
         p.ov = bus8.OutValid; p.ordy = bus8.OutReady; p.out = {56'd0, bus8.Out};
         p.zero = bus8.Zero; p.lt = bus8.LT; p.carry = bus8.Carry;
      end else begin
         p.inv = bus16.InValid; p.inr = bus16.InReady; p.op = bus16.OP;
         p.a = {48'd0, bus16.InputA}; p.b = {48'd0, bus16.InputB};
         p.ov = bus16.OutValid; p.ordy = bus16.OutReady; p.out = {48'd0, bus16.Out};
         p.zero = bus16.Zero; p.lt = bus16.LT; p.carry = bus16.Carry;
      end
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
      if (d == 0) begin
         bus8.InValid = v; bus8.OP = op; bus8.InputA = a[7:0]; bus8.InputB = b[7:0];
      end else begin
         bus16.InValid = v; bus16.OP = op; bus16.InputA = a[15:0]; bus16.InputB = b[15:0];
      end
   endtask

   task automatic set_ordy(input int d, input logic v);
      if (d == 0) bus8.OutReady = v;
      else        bus16.OutReady = v;
   endtask

   // Present one operation and hold it until the DUT accepts it.
   task automatic send(input int d, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      pins_t p;
      int    n;
      drive(d, 1'b1, op, a, b);
      n = 0;
      do begin
         @(posedge clk);
         p = pins(d);
         n++;
      end while (!p.inr && n < 200);
      if (!p.inr) chk("send_timeout", 64'(n), 64'd0);
      #1;
      drive(d, 1'b0, op, a, b);
   endtask

   task automatic wait_log(input int d, input int n);
      for (int i = 0; i < 400 && lg[d].size() < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic chk_rec(input int d, input int i, input string name, input logic [63:0] out,
                          input logic z, input logic lt, input logic c, input int lat);
      if (lg[d].size() > i) begin
         chk({name, "_out"},   lg[d][i].out,   out);
         chk({name, "_zero"},  lg[d][i].zero,  z);
         chk({name, "_lt"},    lg[d][i].lt,    lt);
         chk({name, "_carry"}, lg[d][i].carry, c);
         if (lat > 0) chk({name, "_latency"}, 64'(lg[d][i].xfer - lg[d][i].acc), 64'(lat));
      end else begin
         chk({name, "_missing"}, 64'(lg[d].size()), 64'(i + 1));
      end
   endtask

   pins_t mp;
   item_t mit;
   rec_t  mrec;

   // Monitor: record accepted operations into the model and completed transfers into the log.
   initial forever begin
      @(posedge clk);
      cycle++;
      for (int d = 0; d < 2; d++) begin
         mp = pins(d);
         if (rst_of(d)) begin
            if (mp.ov && mp.ordy && q[d].size() > 0) begin
               mrec.out = mp.out; mrec.zero = mp.zero; mrec.lt = mp.lt; mrec.carry = mp.carry;
               mrec.acc = q[d][0].acc; mrec.xfer = cycle;
               lg[d].push_back(mrec);
               void'(q[d].pop_front());
            end
            if (mp.inv && mp.inr) begin
               mit     = model(mp.op, mp.a, mp.b, width_of(d));
               mit.acc = cycle;
               mit.due = cycle + ((mp.op == OP_MUL) ? width_of(d) + 1 : 1) - 1;
               q[d].push_back(mit);
               n_acc[d]++;
            end
         end
      end
   end

   pins_t cp;
   logic  cexp_v;
   logic  cexp_r;
   string cnm;

   // Compare: every cycle, handshake and (when valid) result against the model.
   initial forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         cp  = pins(d);
         cnm = (d == 0) ? "w8" : "w16";
         if (!rst_of(d)) begin
            q[d].delete();
            chk({cnm, "_rst_out"},   cp.out,   64'd0);
            chk({cnm, "_rst_valid"}, cp.ov,    64'd0);
            chk({cnm, "_rst_zero"},  cp.zero,  64'd0);
            chk({cnm, "_rst_lt"},    cp.lt,    64'd0);
            chk({cnm, "_rst_carry"}, cp.carry, 64'd0);
         end else begin
            cexp_v = 1'b0;
            if (q[d].size() > 0) cexp_v = (cycle >= q[d][0].due);
            cexp_r = (q[d].size() == 0) ? 1'b1 : (cexp_v ? cp.ordy : 1'b0);
            chk({cnm, "_in_ready"},  cp.inr, cexp_r);
            chk({cnm, "_out_valid"}, cp.ov,  cexp_v);
            if (cexp_v) begin
               chk({cnm, "_out"},   cp.out,   q[d][0].out);
               chk({cnm, "_zero"},  cp.zero,  q[d][0].zero);
               chk({cnm, "_lt"},    cp.lt,    q[d][0].lt);
               chk({cnm, "_carry"}, cp.carry, q[d][0].carry);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   item_t mi;
   int    acc_before;
   pins_t sp;

   initial begin
      rst8_n = 1'b0; rst16_n = 1'b0;
      drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
      drive(1, 1'b0, OP_ADD, 64'd0, 64'd0);
      set_ordy(0, 1'b1); set_ordy(1, 1'b1);

      // Pin the model with hand-computed results.
      mi = model(OP_ADD, 64'd200, 64'd100, 8);
      chk("model_add_out", mi.out, 64'd44);  chk("model_add_carry", mi.carry, 64'd1);
      mi = model(OP_SUB, 64'd5, 64'd7, 8);
      chk("model_sub_out", mi.out, 64'd254); chk("model_sub_lt", mi.lt, 64'd1);
      mi = model(OP_MUL, 64'd300, 64'd300, 16);
      chk("model_mul_out", mi.out, 64'd24464); chk("model_mul_carry", mi.carry, 64'd1);
      mi = model(OP_RSVD, 64'd5, 64'd9, 8);
      chk("model_rsvd_zero", mi.zero, 64'd1); chk("model_rsvd_lt", mi.lt, 64'd0);

      repeat (3) @(posedge clk);
      #1; rst8_n = 1'b1; rst16_n = 1'b1;
      @(posedge clk); #1;

      // ADD/SUB wrap, back-to-back.
      lg[0].delete();
      send(0, OP_ADD, 64'd200, 64'd100);
      send(0, OP_SUB, 64'd5, 64'd7);
      send(0, OP_SUB, 64'd9, 64'd9);
      wait_log(0, 3);
      chk_rec(0, 0, "add_wrap", 64'd44, 1'b0, 1'b0, 1'b1, 1);
      chk_rec(0, 1, "sub_wrap", 64'd254, 1'b0, 1'b1, 1'b1, 1);
      chk_rec(0, 2, "sub_zero", 64'd0, 1'b1, 1'b0, 1'b0, 1);
      if (lg[0].size() >= 3) begin
         chk("b2b_gap1", 64'(lg[0][1].xfer - lg[0][0].xfer), 64'd1);
         chk("b2b_gap2", 64'(lg[0][2].xfer - lg[0][1].xfer), 64'd1);
      end else chk("b2b_missing", 64'(lg[0].size()), 64'd3);

      // Logic, SLT and reserved opcode.
      lg[0].delete();
      send(0, OP_AND, 64'hF0, 64'h3C);
      send(0, OP_OR,  64'hF0, 64'h3C);
      send(0, OP_XOR, 64'hF0, 64'h3C);
      send(0, OP_SLT, 64'd3, 64'd4);
      send(0, OP_SLT, 64'd4, 64'd3);
      send(0, OP_RSVD, 64'd5, 64'd9);
      wait_log(0, 6);
      chk_rec(0, 0, "and",   64'h30, 1'b0, 1'b0, 1'b0, 1);
      chk_rec(0, 1, "or",    64'hFC, 1'b0, 1'b0, 1'b0, 1);
      chk_rec(0, 2, "xor",   64'hCC, 1'b0, 1'b0, 1'b0, 1);
      chk_rec(0, 3, "slt_t", 64'd1,  1'b0, 1'b1, 1'b0, 1);
      chk_rec(0, 4, "slt_f", 64'd0,  1'b1, 1'b0, 1'b0, 1);
      chk_rec(0, 5, "rsvd",  64'd0,  1'b1, 1'b0, 1'b0, 1);

      // Multiply.
      lg[0].delete();
      send(0, OP_MUL, 64'd13, 64'd11);
      send(0, OP_MUL, 64'd255, 64'd255);
      send(0, OP_MUL, 64'd0, 64'd77);
      wait_log(0, 3);
      chk_rec(0, 0, "mul_13x11",   64'd143, 1'b0, 1'b0, 1'b0, 9);
      chk_rec(0, 1, "mul_255x255", 64'd1,   1'b0, 1'b0, 1'b1, 9);
      chk_rec(0, 2, "mul_0x77",    64'd0,   1'b1, 1'b1, 1'b0, 9);

      // Reset in the third BUSY cycle discards the multiply.
      lg[0].delete();
      send(0, OP_ADD, 64'd3, 64'd4);
      send(0, OP_MUL, 64'd13, 64'd11);
      @(posedge clk); @(posedge clk); #1;
      rst8_n = 1'b0;
      @(negedge clk);
      sp = pins(0);
      chk("rst_mid_out", sp.out, 64'd0);   chk("rst_mid_valid", sp.ov, 64'd0);
      chk("rst_mid_zero", sp.zero, 64'd0); chk("rst_mid_carry", sp.carry, 64'd0);
      @(posedge clk); #1;
      rst8_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         sp = pins(0);
         chk("post_rst_stale_valid", sp.ov, 64'd0);
         chk("post_rst_in_ready", sp.inr, 64'd1);
      end
      chk_rec(0, 0, "pre_rst_add", 64'd7, 1'b0, 1'b1, 1'b0, 1);
      chk("rst_log_count", 64'(lg[0].size()), 64'd1);
      @(posedge clk); #1;

      // Backpressure in HOLD, then simultaneous transfer and accept.
      lg[0].delete();
      set_ordy(0, 1'b0);
      send(0, OP_ADD, 64'd7, 64'd8);
      acc_before = n_acc[0];
      drive(0, 1'b1, OP_ADD, 64'd1, 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sp = pins(0);
         chk("bp_in_ready", sp.inr, 64'd0);
         chk("bp_out", sp.out, 64'd15);
         chk("bp_valid", sp.ov, 64'd1);
         chk("bp_carry", sp.carry, 64'd0);
         @(posedge clk); #1;
      end
      chk("bp_no_accept", 64'(n_acc[0]), 64'(acc_before));
      set_ordy(0, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, OP_ADD, 64'd1, 64'd1);
      @(negedge clk);
      sp = pins(0);
      chk("bp_new_out", sp.out, 64'd2);
      chk("bp_new_valid", sp.ov, 64'd1);
      wait_log(0, 2);
      chk_rec(0, 0, "bp_old", 64'd15, 1'b0, 1'b1, 1'b0, 0);
      chk_rec(0, 1, "bp_new", 64'd2,  1'b0, 1'b0, 1'b0, 1);

      // WIDTH=16 instance.
      lg[1].delete();
      send(1, OP_MUL, 64'd300, 64'd300);
      send(1, OP_ADD, 64'hFFFF, 64'd1);
      wait_log(1, 2);
      chk_rec(1, 0, "w16_mul", 64'd24464, 1'b0, 1'b0, 1'b1, 17);
      chk_rec(1, 1, "w16_add", 64'd0,     1'b1, 1'b0, 1'b1, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("w8_drained",  64'(q[0].size()), 64'd0);
      chk("w16_drained", 64'(q[1].size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
